multi_mode_timer: RTL

- Parametrised successor of the single 1-second overflow timer: programmable period, one-shot or periodic mode, pause/resume without losing count, an overflow-event counter, and busy/done status.
- Sits between the system clock and control logic (display refresh, debounce windows, game/second ticks).
- One instance replaces several hard-coded per-period timers.

---
 rtl/multi_mode_timer.sv | 115 +++++++++++
 1 files changed

// File: rtl/multi_mode_timer.sv
// rtl/multi_mode_timer.sv - programmable one-shot/periodic cycle timer with pause and overflow counter
module multi_mode_timer #(
    parameter int CNT_W          = 26,
    parameter int DEFAULT_PERIOD = 50_000_000,
    parameter int OVF_W          = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             enable,
    input  logic             oneshot,
    input  logic             period_load,
    input  logic [CNT_W-1:0] period_in,
    output logic             ovflw,
    output logic [CNT_W-1:0] count,
    output logic [OVF_W-1:0] ovf_cnt,
    output logic             busy,
    output logic             done,
    output logic             load_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [OVF_W-1:0] ovf_cnt_q, ovf_cnt_d;
    logic             mode_q, mode_d;
    logic             ovflw_q, ovflw_d;
    logic             load_err_q, load_err_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            period_q   <= CNT_W'(DEFAULT_PERIOD);
            ovf_cnt_q  <= '0;
            mode_q     <= 1'b0;
            ovflw_q    <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            period_q   <= period_d;
            ovf_cnt_q  <= ovf_cnt_d;
            mode_q     <= mode_d;
            ovflw_q    <= ovflw_d;
            load_err_q <= load_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        period_d   = period_q;
        ovf_cnt_d  = ovf_cnt_q;
        mode_d     = mode_q;
        ovflw_d    = 1'b0;
        load_err_d = 1'b0;

        if (stop) begin
            state_d    = ST_IDLE;
            count_d    = '0;
            load_err_d = period_load;
        end else if (start) begin
            // A coincident period_load loses to start and is reported as rejected
            count_d    = '0;
            ovf_cnt_d  = '0;
            mode_d     = oneshot;
            state_d    = enable ? ST_COUNT : ST_PAUSE;
            load_err_d = period_load;
        end else begin
            if (period_load) begin
                if (state_q == ST_IDLE || state_q == ST_DONE) begin
                    period_d = (period_in == '0) ? CNT_W'(1) : period_in;
                end else begin
                    load_err_d = 1'b1;
                end
            end

            case (state_q)
                ST_COUNT: begin
                    if (!enable) begin
                        state_d = ST_PAUSE;
                    end else if (count_q == period_q - CNT_W'(1)) begin
                        count_d   = '0;
                        ovflw_d   = 1'b1;
                        ovf_cnt_d = ovf_cnt_q + OVF_W'(1);
                        if (mode_q) state_d = ST_DONE;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
                ST_PAUSE: begin
                    if (enable) state_d = ST_COUNT;
                end
                default: ;
            endcase
        end
    end

    assign ovflw    = ovflw_q;
    assign count    = count_q;
    assign ovf_cnt  = ovf_cnt_q;
    assign busy     = (state_q == ST_COUNT) || (state_q == ST_PAUSE);
    assign done     = (state_q == ST_DONE);
    assign load_err = load_err_q;

endmodule
